inicializacion: RTL and testbench



---
 rtl/inicializacion_pkg.sv | 20 ++
 rtl/inicializacion_contador_16.sv | 28 ++
 rtl/inicializacion.sv | 62 ++++++
 tb/tb_inicializacion.sv | 127 ++++++++++++
 4 files changed

// File: rtl/inicializacion_pkg.sv
// Shared constants for the RTC start-up sequencer: prescaler/step sizes,
// output-select encodings and the address/data initialisation table.
package inicializacion_pkg;

    localparam int CNT16_MAX = 15;
    localparam int N_PASOS   = 8;
    localparam int PASO_W    = 3;

    localparam logic [1:0] SEL_DIR  = 2'b00;
    localparam logic [1:0] SEL_DATO = 2'b01;
    localparam logic [1:0] SEL_PASO = 2'b10;
    localparam logic [1:0] SEL_FIN  = 2'b11;

    // Each entry is {dir, dato}: RTC register address in the high byte.
    localparam logic [15:0] TABLA [N_PASOS] = '{
        16'h0210, 16'h0200, 16'h10D2, 16'h0100,
        16'h0000, 16'h0300, 16'h0400, 16'h0500
    };

endpackage

// File: rtl/inicializacion_contador_16.sv
// Modulo-(MAX+1) prescaler with count enable and synchronous active-low reset;
// tick flags the enabled cycle in which the count wraps.
module contador_16
    import inicializacion_pkg::*;
#(
    parameter int MAX = CNT16_MAX,
    parameter int W   = $clog2(CNT16_MAX + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] cont,
    output logic         tick
);

    localparam logic [W-1:0] MAX_C = W'(MAX);

    assign tick = en && (cont == MAX_C);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cont <= '0;
        end else if (en) begin
            cont <= (cont == MAX_C) ? '0 : cont + 1'b1;
        end
    end

endmodule

// File: rtl/inicializacion.sv
// RTC start-up sequencer: walks the initialisation table one step per prescaler
// tick and presents the byte chosen by Control on a registered output.
module inicializacion
    import inicializacion_pkg::*;
(
    input  logic       reloj,
    input  logic       resetM,
    input  logic       enable_cont_16,
    input  logic       enable_cont_I,
    input  logic [1:0] Control,
    output logic [7:0] Inicie
);

    localparam logic [PASO_W-1:0] PASO_ULT = PASO_W'(N_PASOS - 1);

    logic [3:0]        cont16;
    logic              tick;
    logic [PASO_W-1:0] paso;
    logic [15:0]       entrada;
    logic [7:0]        sel;

    contador_16 #(
        .MAX (CNT16_MAX),
        .W   (4)
    ) u_contador (
        .clk   (reloj),
        .rst_n (resetM),
        .en    (enable_cont_16),
        .cont  (cont16),
        .tick  (tick)
    );

    // Ticks arriving while enable_cont_I is low are dropped, not queued;
    // the last step is sticky so the sequence never replays on its own.
    always_ff @(posedge reloj) begin
        if (!resetM) begin
            paso <= '0;
        end else if (tick && enable_cont_I && (paso != PASO_ULT)) begin
            paso <= paso + 1'b1;
        end
    end

    always_comb begin
        sel     = 8'h00;
        entrada = TABLA[paso];
        case (Control)
            SEL_DIR:  sel = entrada[15:8];
            SEL_DATO: sel = entrada[7:0];
            SEL_PASO: sel = 8'(paso);
            SEL_FIN:  sel = (paso == PASO_ULT) ? 8'hFF : 8'h00;
        endcase
    end

    always_ff @(posedge reloj) begin
        if (!resetM) begin
            Inicie <= 8'h00;
        end else begin
            Inicie <= sel;
        end
    end

endmodule

// File: tb/tb_inicializacion.sv
// Directed, table-driven bench for the RTC start-up sequencer with
// hand-computed expected Inicie values and prescaler count checks.
module tb_inicializacion;

    logic       reloj;
    logic       resetM;
    logic       enable_cont_16;
    logic       enable_cont_I;
    logic [1:0] Control;
    logic [7:0] Inicie;

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic       rst_n;
        logic       en16;
        logic       en_i;
        logic [1:0] ctrl;
        int         reps;
        logic [7:0] exp_out;
        bit         chk_cnt;
        logic [3:0] exp_cnt;
    } vec_t;

    vec_t vecs[$];

    inicializacion dut (
        .reloj          (reloj),
        .resetM         (resetM),
        .enable_cont_16 (enable_cont_16),
        .enable_cont_I  (enable_cont_I),
        .Control        (Control),
        .Inicie         (Inicie)
    );

    initial reloj = 1'b0;
    always #5 reloj = ~reloj;

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual === expected) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drive one record's inputs, let the requested number of edges pass, then sample.
    task automatic applyStimulus(input vec_t v, input int idx);
        resetM         = v.rst_n;
        enable_cont_16 = v.en16;
        enable_cont_I  = v.en_i;
        Control        = v.ctrl;
        repeat (v.reps) @(posedge reloj);
        #1;
        checkOutput($sformatf("vec%0d_inicie", idx), Inicie, v.exp_out);
        if (v.chk_cnt) begin
            checkOutput($sformatf("vec%0d_cont16", idx), 8'(dut.u_contador.cont), 8'(v.exp_cnt));
        end
    endtask

    initial begin
        // Prescaler alone from reset, step counter disabled.
        vecs.push_back('{1'b1, 1'b1, 1'b0, 2'b10, 15, 8'h00, 1'b1, 4'd15});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 2'b10,  1, 8'h00, 1'b1, 4'd0});
        // Stepping through the table up to saturation.
        vecs.push_back('{1'b1, 1'b1, 1'b1, 2'b01, 15, 8'h10, 1'b1, 4'd15});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 2'b01,  1, 8'h10, 1'b1, 4'd0});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 2'b01,  1, 8'h00, 1'b0, 4'd0});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 2'b00,  1, 8'h02, 1'b0, 4'd0});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 2'b10,  1, 8'h01, 1'b0, 4'd0});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 2'b10, 13, 8'h01, 1'b1, 4'd0});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 2'b00,  1, 8'h10, 1'b0, 4'd0});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 2'b01,  1, 8'hD2, 1'b0, 4'd0});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 2'b11,  1, 8'h00, 1'b0, 4'd0});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 2'b00, 14, 8'h01, 1'b0, 4'd0});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 2'b10, 16, 8'h04, 1'b0, 4'd0});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 2'b00, 16, 8'h03, 1'b0, 4'd0});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 2'b00, 16, 8'h04, 1'b0, 4'd0});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 2'b00, 16, 8'h05, 1'b0, 4'd0});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 2'b11,  1, 8'hFF, 1'b0, 4'd0});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 2'b10,  1, 8'h07, 1'b0, 4'd0});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 2'b10, 40, 8'h07, 1'b0, 4'd0});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 2'b11,  1, 8'hFF, 1'b0, 4'd0});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 2'b01,  1, 8'h00, 1'b0, 4'd0});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 2'b00,  1, 8'h05, 1'b1, 4'd14});
        // One-cycle reset from the saturated state.
        vecs.push_back('{1'b0, 1'b1, 1'b1, 2'b10,  1, 8'h00, 1'b1, 4'd0});
        // Reach step 1 with cont16 at 9, freeze prescaler, then drop only enable_cont_I.
        vecs.push_back('{1'b1, 1'b1, 1'b1, 2'b10, 25, 8'h01, 1'b1, 4'd9});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 2'b10, 20, 8'h01, 1'b1, 4'd9});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 2'b10, 10, 8'h01, 1'b1, 4'd3});
        // Lost tick must not be replayed: next advance only at the next wrap.
        vecs.push_back('{1'b1, 1'b1, 1'b1, 2'b10, 13, 8'h01, 1'b1, 4'd0});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 2'b10,  1, 8'h02, 1'b1, 4'd1});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 2'b10, 31, 8'h03, 1'b1, 4'd0});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 2'b10,  1, 8'h04, 1'b1, 4'd1});
        // Mid-run reset at step 4, sequence restarts from step 0.
        vecs.push_back('{1'b0, 1'b1, 1'b1, 2'b01,  1, 8'h00, 1'b1, 4'd0});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 2'b10,  1, 8'h00, 1'b1, 4'd1});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 2'b01,  1, 8'h10, 1'b1, 4'd2});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 2'b00,  1, 8'h02, 1'b1, 4'd3});

        resetM         = 1'b0;
        enable_cont_16 = 1'b1;
        enable_cont_I  = 1'b1;
        Control        = 2'b01;

        // Long reset with enables high: output and step must stay cleared.
        for (int i = 0; i < 35; i++) begin
            Control = i[0] ? 2'b10 : 2'b01;
            @(posedge reloj);
            #1;
            checkOutput($sformatf("reset_hold%0d", i), Inicie, 8'h00);
        end
        checkOutput("reset_hold_cont16", 8'(dut.u_contador.cont), 8'h00);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i], i);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
